rst_seq_clockstop: RTL and testbench

RST_SEQ_CLOCKSTOP -- requirements
Module: rst_seq_clockstop

---
 rtl/rst_seq_clockstop.sv | 77 +++++++
 tb/tb_rst_seq_clockstop.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rst_seq_clockstop.sv
// rst_seq_clockstop: releases per-domain resets one at a time with the target clock stopped around each release
module rst_seq_clockstop #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int STOP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] deassert,
  input  logic [NUM_CH-1:0] assert_req,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {SCAN, STOP, WAIT, START} state_t;
  state_t            state;
  logic [7:0]        cnt;
  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] dsync, pend, low_oh, rst_nxt;
  assign dsync  = sync_q[SYNC_STAGES-1];
  assign pend   = rst_out & dsync;
  assign low_oh = pend & (~pend + NUM_CH'(1));
  assign done   = ~|rst_out & ~busy;
  // bring the asynchronous release requests into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= deassert;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end
  // assert requests always set reset and beat a release landing in the same cycle
  always_comb begin
    rst_nxt = rst_out | assert_req;
    rst_nxt = (state == STOP) ? rst_nxt & ~(sel_oh & ~assert_req) : rst_nxt;
  end
  // single sequencer: stop clock, drop reset, hold stopped, restart clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SCAN;
      cnt     <= '0;
      sel_oh  <= '0;
      clk_en  <= '1;
      rst_out <= '1;
      busy    <= 1'b0;
    end else begin
      rst_out <= rst_nxt;
      case (state)
        SCAN: if (|pend) begin
          sel_oh <= low_oh;
          clk_en <= clk_en & ~low_oh;
          state  <= STOP;
          busy   <= 1'b1;
        end
        STOP: begin
          cnt   <= 8'(STOP_CYCLES - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == 8'd0) state <= START;
              else cnt <= cnt - 8'd1;
        START: begin
          clk_en <= clk_en | sel_oh;
          state  <= SCAN;
          busy   <= 1'b0;
        end
        default: begin
          clk_en <= '1;
          state  <= SCAN;
          busy   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rst_seq_clockstop.sv
// tb_rst_seq_clockstop: directed checks of the clock-stop reset sequencer
module tb_rst_seq_clockstop;
  logic       clk = 1'b0;
  logic       rst, rst_b;
  logic [3:0] deassert_a, areq_a, ce_a, ro_a;
  logic [1:0] deassert_b, areq_b, ce_b, ro_b;
  logic       busy_a, done_a, busy_b, done_b;
  int         errors = 0, checks = 0;
  int         w, l;
  logic       rf, ra;
  logic [3:0] cev;
  always #5 clk = ~clk;
  rst_seq_clockstop #(.NUM_CH(4), .SYNC_STAGES(3), .STOP_CYCLES(8)) dut_a (
    .clk(clk), .rst(rst), .deassert(deassert_a), .assert_req(areq_a),
    .clk_en(ce_a), .rst_out(ro_a), .busy(busy_a), .done(done_a));
  rst_seq_clockstop #(.NUM_CH(2), .SYNC_STAGES(3), .STOP_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b), .deassert(deassert_b), .assert_req(areq_b),
    .clk_en(ce_b), .rst_out(ro_b), .busy(busy_b), .done(done_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] ce(input int which);
    return which != 0 ? {2'b11, ce_b} : ce_a;
  endfunction
  function automatic logic [3:0] ro(input int which);
    return which != 0 ? {2'b00, ro_b} : ro_a;
  endfunction
  task automatic seq(input int which, input int ch, output int wait_n, output int low_n,
                     output logic r_fall, output logic r_after, output logic [3:0] ce_fall);
    wait_n = 0;
    low_n  = 0;
    r_after = 1'bx;
    while (ce(which)[ch] && wait_n < 200) begin
      step();
      wait_n++;
    end
    r_fall  = ro(which)[ch];
    ce_fall = ce(which);
    while (!ce(which)[ch] && low_n < 200) begin
      if (low_n == 1) r_after = ro(which)[ch];
      low_n++;
      step();
    end
  endtask
  initial begin
    rst = 1'b1; rst_b = 1'b1;
    deassert_a = '0; areq_a = '0; deassert_b = '0; areq_b = '0;
    repeat (3) step();
    chk("rst_rst_out", 32'(ro_a), 32'hF);
    chk("rst_clk_en", 32'(ce_a), 32'hF);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_b_rst_out", 32'(ro_b), 32'h3);
    rst_b = 1'b0;
    rst = 1'b0;
    deassert_a = 4'b0100;
    seq(0, 2, w, l, rf, ra, cev);
    chk("t1_wait", 32'(w), 4);
    chk("t1_low", 32'(l), 10);
    chk("t1_rst_at_fall", 32'(rf), 1);
    chk("t1_rst_after", 32'(ra), 0);
    chk("t1_ce_fall", 32'(cev), 32'hB);
    chk("t1_rst_out", 32'(ro_a), 32'hB);
    chk("t1_busy", 32'(busy_a), 0);
    repeat (3) step();
    chk("t1_done", 32'(done_a), 0);
    deassert_a = 4'hF;
    seq(0, 0, w, l, rf, ra, cev);
    chk("t2_wait0", 32'(w), 4);
    chk("t2_low0", 32'(l), 10);
    chk("t2_ce0", 32'(cev), 32'hE);
    seq(0, 1, w, l, rf, ra, cev);
    chk("t2_wait1", 32'(w), 1);
    chk("t2_ce1", 32'(cev), 32'hD);
    chk("t2_done_mid", 32'(done_a), 0);
    seq(0, 3, w, l, rf, ra, cev);
    chk("t2_wait3", 32'(w), 1);
    chk("t2_ce3", 32'(cev), 32'h7);
    chk("t2_low3", 32'(l), 10);
    chk("t2_done", 32'(done_a), 1);
    chk("t2_rst_out", 32'(ro_a), 0);
    areq_a = 4'b0010;
    step();
    areq_a = '0;
    chk("t3_rst_out", 32'(ro_a), 32'h2);
    chk("t3_clk_en", 32'(ce_a), 32'hF);
    chk("t3_done", 32'(done_a), 0);
    seq(0, 1, w, l, rf, ra, cev);
    chk("t3_wait", 32'(w), 1);
    chk("t3_low", 32'(l), 10);
    chk("t3_rst_after", 32'(ra), 0);
    areq_a = 4'b0001;
    step();
    areq_a = '0;
    step();
    chk("t4_stop_ce", 32'(ce_a), 32'hE);
    areq_a = 4'b0001;
    step();
    areq_a = '0;
    chk("t4_rst_held", 32'(ro_a[0]), 1);
    l = 1;
    while (!ce_a[0] && l < 200) begin
      l++;
      step();
    end
    chk("t4_low", 32'(l), 10);
    chk("t4_rst_still", 32'(ro_a[0]), 1);
    seq(0, 0, w, l, rf, ra, cev);
    chk("t4_rewait", 32'(w), 1);
    chk("t4_relow", 32'(l), 10);
    chk("t4_rst_out", 32'(ro_a), 0);
    areq_a = 4'b0100;
    step();
    areq_a = '0;
    step();
    step();
    step();
    chk("t5_busy_wait", 32'(busy_a), 1);
    chk("t5_ce_wait", 32'(ce_a), 32'hB);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_out", 32'(ro_a), 32'hF);
    chk("t5_clk_en", 32'(ce_a), 32'hF);
    chk("t5_busy", 32'(busy_a), 0);
    deassert_b = 2'b01;
    step();
    deassert_b = 2'b00;
    seq(1, 0, w, l, rf, ra, cev);
    chk("t6_wait", 32'(w), 3);
    chk("t6_low", 32'(l), 3);
    chk("t6_rst_at_fall", 32'(rf), 1);
    chk("t6_rst_after", 32'(ra), 0);
    chk("t6_ce_fall", 32'(cev), 32'hE);
    repeat (4) step();
    chk("t6_rst_out", 32'(ro_b), 32'h2);
    chk("t6_busy", 32'(busy_b), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
